// File: rtl/i2c_pkg.sv
// Shared I2C definitions: shift-engine state encoding, SDA idle level
// and the bit-count width helper also used by the bus-phase controller.
package i2c_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_ACK   = 2'd2
  } state_e;

  // Open-drain SDA: a 1 on the driver input releases the line.
  localparam logic SDA_RELEASED = 1'b1;

  // Width needed to hold a count of 0..w inclusive.
  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/i2c_bit_counter.sv
// Saturating transfer bit counter: clear on clr_i, +1 on inc_i, stops at WIDTH.
// Ports: clk_i, rst_ni (sync, active-low), clr_i, inc_i -> count_o, last_o.
module i2c_bit_counter
  import i2c_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CW    = cnt_w(WIDTH)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clr_i,
  input  logic          inc_i,
  output logic [CW-1:0] count_o,
  output logic          last_o
);

  logic [CW-1:0] count_q, count_d;
  logic          term;

  assign term   = (count_q == CW'(WIDTH));
  // The strobe arriving at this count completes the word.
  assign last_o = (count_q == CW'(WIDTH - 1));

  always_comb begin
    count_d = count_q;
    if (clr_i)
      count_d = '0;
    else if (inc_i && !term)
      count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni)
      count_q <= '0;
    else
      count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/i2c_shift_engine.sv
// I2C data shift engine: parallel load, one bit out/in per ShiftEn, Done pulse.
// Ports: CLOCK, Reset(sync low), Load, SentData, ShiftEn, ShiftIn -> ShiftOut,
//   ReceivedData, BitCount, Busy, Done. Define I2C_ACK_SLOT_EN for the 9th ACK
//   slot, which adds AckOut (in) and AckReceived (out).
module i2c_shift_engine
  import i2c_pkg::*;
#(
  parameter  int WIDTH     = 8,
  parameter  bit MSB_FIRST = 1'b1,
  localparam int CW        = cnt_w(WIDTH)
) (
  input  logic             CLOCK,
  input  logic             Reset,
  input  logic             Load,
  input  logic [WIDTH-1:0] SentData,
  input  logic             ShiftEn,
  input  logic             ShiftIn,
`ifdef I2C_ACK_SLOT_EN
  input  logic             AckOut,
  output logic             AckReceived,
`endif
  output logic             ShiftOut,
  output logic [WIDTH-1:0] ReceivedData,
  output logic [CW-1:0]    BitCount,
  output logic             Busy,
  output logic             Done
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             sout_q, sout_d;
  logic             done_q, done_d;
  logic             clr, inc, last;

  logic [WIDTH-1:0] shifted;
  logic             nxt_bit;
  logic             first_bit;

`ifdef I2C_ACK_SLOT_EN
  logic ack_q, ack_d;
`endif

  i2c_bit_counter #(
    .WIDTH(WIDTH)
  ) u_cnt (
    .clk_i  (CLOCK),
    .rst_ni (Reset),
    .clr_i  (clr),
    .inc_i  (inc),
    .count_o(BitCount),
    .last_o (last)
  );

  // Received bits enter at the far end while the next transmit bit is
  // taken from one position behind the outgoing one.
  always_comb begin
    if (MSB_FIRST) begin
      shifted   = {data_q[WIDTH-2:0], ShiftIn};
      nxt_bit   = data_q[WIDTH-2];
      first_bit = SentData[WIDTH-1];
    end else begin
      shifted   = {ShiftIn, data_q[WIDTH-1:1]};
      nxt_bit   = data_q[1];
      first_bit = SentData[0];
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    sout_d  = sout_q;
    done_d  = 1'b0;
    clr     = 1'b0;
    inc     = 1'b0;
`ifdef I2C_ACK_SLOT_EN
    ack_d   = ack_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        // Load has priority; a coincident ShiftEn is dropped.
        if (Load) begin
          data_d  = SentData;
          sout_d  = first_bit;
          clr     = 1'b1;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (ShiftEn) begin
          inc    = 1'b1;
          data_d = shifted;
          sout_d = nxt_bit;
          if (last) begin
`ifdef I2C_ACK_SLOT_EN
            sout_d  = AckOut;
            state_d = ST_ACK;
`else
            sout_d  = SDA_RELEASED;
            done_d  = 1'b1;
            state_d = ST_IDLE;
`endif
          end
        end
      end
`ifdef I2C_ACK_SLOT_EN
      ST_ACK: begin
        if (ShiftEn) begin
          ack_d   = ShiftIn;
          sout_d  = SDA_RELEASED;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
`endif
      default: begin
        sout_d  = SDA_RELEASED;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (!Reset) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      sout_q  <= SDA_RELEASED;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      sout_q  <= sout_d;
      done_q  <= done_d;
    end
  end

`ifdef I2C_ACK_SLOT_EN
  always_ff @(posedge CLOCK) begin
    if (!Reset)
      ack_q <= 1'b1;
    else
      ack_q <= ack_d;
  end

  assign AckReceived = ack_q;
`endif

  assign ShiftOut     = sout_q;
  assign ReceivedData = data_q;
  assign Busy         = (state_q != ST_IDLE);
  assign Done         = done_q;

endmodule
